// File: rtl/rx_block_assembler_pkg.sv
// Shared types and constants for the UART-to-hash frame assembler.
// Holds the frame state encoding, the default sync marker and the checksum helper.
package rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CHECK,
    DONE
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         CHK_W             = 8;

  // Running frame checksum is a plain XOR of every payload byte.
  function automatic logic [CHK_W-1:0] chk_update(input logic [CHK_W-1:0] chk,
                                                  input logic [7:0]       data);
    return chk ^ data;
  endfunction

endpackage

// File: rtl/rx_block_assembler_idle_timer.sv
// Counts clocks since the last accepted byte; flags expiry on the last allowed idle clock.
module idle_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = enable && (count_reg == LAST);

endmodule

// File: rtl/rx_block_assembler.sv
// Frames SYNC + BLOCK_BYTES payload + XOR checksum from the UART byte stream into one block
// register, and signals the control fsm when a verified block is ready for hashing.
module rx_block_assembler
  import rx_pkg::*;
#(
  parameter int         BLOCK_BYTES    = 64,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  localparam int        W              = 8 * BLOCK_BYTES,
  localparam int        CW             = $clog2(BLOCK_BYTES + 1)
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          read_enable,
  output logic [W-1:0]  block_o,
  output logic          finished_recieving,
  output logic          rx_error,
  output logic [CW-1:0] byte_count
);

  rx_state_t        state_reg, state_next;
  logic [W-1:0]     shift_reg;
  logic [W-1:0]     block_reg;
  logic [CHK_W-1:0] chk_reg;
  logic [CW-1:0]    count_reg;
  logic             finished_reg;
  logic             error_reg;

  logic accept;
  logic in_frame;
  logic timer_expired;
  logic take_sync;
  logic take_payload;
  logic load_block;
  logic error_next;
  logic to_idle;

  assign accept   = rx_valid & read_enable;
  assign in_frame = (state_reg == PAYLOAD) || (state_reg == CHECK);

  idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .rst_i  (rst_i),
    .clear  (accept | ~in_frame),
    .enable (in_frame),
    .expired(timer_expired)
  );

  // Losing read_enable mid-frame is a silent abort and takes priority over a timeout.
  always_comb begin
    state_next   = state_reg;
    take_sync    = 1'b0;
    take_payload = 1'b0;
    load_block   = 1'b0;
    error_next   = 1'b0;
    to_idle      = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (accept && (rx_data == SYNC_BYTE)) begin
          state_next = PAYLOAD;
          take_sync  = 1'b1;
        end
      end
      PAYLOAD: begin
        if (!read_enable) begin
          state_next = IDLE;
          to_idle    = 1'b1;
        end else if (accept) begin
          take_payload = 1'b1;
          if (count_reg == CW'(BLOCK_BYTES - 1)) state_next = CHECK;
        end else if (timer_expired) begin
          state_next = IDLE;
          error_next = 1'b1;
          to_idle    = 1'b1;
        end
      end
      CHECK: begin
        if (!read_enable) begin
          state_next = IDLE;
          to_idle    = 1'b1;
        end else if (accept) begin
          if (rx_data == chk_reg) begin
            state_next = DONE;
            load_block = 1'b1;
          end else begin
            state_next = IDLE;
            error_next = 1'b1;
            to_idle    = 1'b1;
          end
        end else if (timer_expired) begin
          state_next = IDLE;
          error_next = 1'b1;
          to_idle    = 1'b1;
        end
      end
      DONE: begin
        if (!read_enable) begin
          state_next = IDLE;
          to_idle    = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        to_idle    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state_reg    <= IDLE;
      block_reg    <= '0;
      chk_reg      <= '0;
      count_reg    <= '0;
      finished_reg <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      error_reg    <= error_next;
      finished_reg <= (state_next == DONE);
      if (take_sync) begin
        chk_reg   <= '0;
        count_reg <= '0;
      end
      if (take_payload) begin
        chk_reg   <= chk_update(chk_reg, rx_data);
        count_reg <= count_reg + 1'b1;
      end
      if (load_block) block_reg <= shift_reg;
      if (to_idle) count_reg <= '0;
    end
  end

  // Payload shifter carries no reset; only block_reg is architecturally visible.
  always_ff @(posedge clk) begin
    if (take_payload) shift_reg <= {shift_reg[W-9:0], rx_data};
  end

  assign block_o            = block_reg;
  assign finished_recieving = finished_reg;
  assign rx_error           = error_reg;
  assign byte_count         = count_reg;

endmodule
